// File: rtl/mouse_pkg.sv
// mouse_pkg
//   Shared definitions for the PS/2 mouse initialisation controller:
//   - PS/2 command / response codes used by the start-up script
//   - FSM state enumeration
//   - script step type {is_tx, code} and the 10-entry script ROM
//   - small lookup helpers over the script ROM
package mouse_pkg;

  // PS/2 codes used by the initialisation script
  localparam logic [7:0] PS2_RESET     = 8'hFF;  // host: reset
  localparam logic [7:0] PS2_ACK       = 8'hFA;  // device: acknowledge
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;  // device: self-test passed
  localparam logic [7:0] PS2_MOUSE_ID  = 8'h00;  // device: standard mouse ID
  localparam logic [7:0] PS2_RESEND    = 8'hFE;  // device: resend last command
  localparam logic [7:0] PS2_SET_RATE  = 8'hF3;  // host: set sample rate
  localparam logic [7:0] PS2_RATE_100  = 8'h64;  // host: rate argument, 100 samples/s
  localparam logic [7:0] PS2_EN_STREAM = 8'hF4;  // host: enable data reporting

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // One script entry: either a byte to transmit or a byte to expect back.
  typedef struct packed {
    logic       is_tx;
    logic [7:0] code;
  } step_t;

  localparam logic [3:0] LAST_STEP = 4'd9;

  localparam step_t [0:9] SCRIPT_ROM = '{
    '{1'b1, PS2_RESET},
    '{1'b0, PS2_ACK},
    '{1'b0, PS2_BAT_OK},
    '{1'b0, PS2_MOUSE_ID},
    '{1'b1, PS2_SET_RATE},
    '{1'b0, PS2_ACK},
    '{1'b1, PS2_RATE_100},
    '{1'b0, PS2_ACK},
    '{1'b1, PS2_EN_STREAM},
    '{1'b0, PS2_ACK}
  };

  // Byte of a step; indices past the end of the script read as 00.
  function automatic logic [7:0] step_code(input logic [3:0] idx);
    logic [7:0] code;
    code = 8'h00;
    if (idx <= LAST_STEP) code = SCRIPT_ROM[idx].code;
    return code;
  endfunction

  // Direction of a step; indices past the end of the script read as RX.
  function automatic logic step_is_tx(input logic [3:0] idx);
    logic is_tx;
    is_tx = 1'b0;
    if (idx <= LAST_STEP) is_tx = SCRIPT_ROM[idx].is_tx;
    return is_tx;
  endfunction

  // Nearest TX step strictly before idx (where a resend request returns to).
  function automatic logic [3:0] prev_tx_step(input logic [3:0] idx);
    logic [3:0] tgt;
    tgt = 4'd0;
    for (int k = 0; k <= 9; k++) begin
      if ((4'(k) < idx) && SCRIPT_ROM[4'(k)].is_tx) tgt = 4'(k);
    end
    return tgt;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// delay_timer
//   Up-counter that reports when LIMIT cycles have elapsed since the last load.
//   The count is cleared by reset or i_load and then advances once per cycle,
//   saturating on its last value; o_expired is high during the LIMIT-th cycle
//   after the load (and stays high until the next load). LIMIT must be >= 1.
// Ports
//   clk        system clock
//   rst        synchronous active-high reset (clears the count)
//   i_load     restart the interval
//   o_expired  interval has elapsed
module delay_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_expired = w_at_last;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_count <= '0;
    end else if (!w_at_last) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/mouse_init_ctrl.sv
// mouse_init_ctrl
//   Walks a PS/2 mouse through its power-up script (reset, set sample rate
//   100, enable streaming), handling resend requests, bad responses and
//   per-step timeouts with a bounded number of retries.
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   reinit      one-cycle restart request, honoured only in DONE / ERROR
//   tx_data     command byte to the transmit engine
//   tx_valid    tx_data valid; held with tx_data until tx_ready
//   tx_ready    transmit engine accepts the byte
//   tx_done     one-cycle pulse: byte fully sent
//   rx_data     received byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   init_done   mouse is streaming
//   init_error  retries exhausted
//   step_idx    current script step
//   retry_cnt   failed attempts so far
module mouse_init_ctrl
  import mouse_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 4_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 40_000_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reinit,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       init_done,
  output logic       init_error,
  output logic [3:0] step_idx,
  output logic [1:0] retry_cnt
);

  // retry_cnt value at which the next failure is the last one allowed
  localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRIES - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_step, w_step_next;
  logic [1:0] r_retry, w_retry_next;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic       r_init_done;
  logic       r_init_error;

  logic       w_enter_step;
  logic       w_advance;
  logic       w_fail;
  logic [3:0] w_fail_target;
  logic       w_active;
  logic       w_startup_expired;
  logic       w_timeout_expired;
  logic       w_startup_load;
  logic       w_timeout_load;

  // Startup timer runs only while in STARTUP.
  assign w_startup_load = (r_state != ST_STARTUP);

  delay_timer #(
    .LIMIT (STARTUP_CYCLES)
  ) u_startup_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_startup_load),
    .o_expired (w_startup_expired)
  );

  // Step timer restarts on every step entry; SEND and WAIT_TX of one TX step
  // share a single interval. Outside the active states it is held cleared.
  assign w_active       = (r_state == ST_SEND) || (r_state == ST_WAIT_TX) ||
                          (r_state == ST_WAIT_RX);
  assign w_timeout_load = w_enter_step || !w_active;

  delay_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_timeout_load),
    .o_expired (w_timeout_expired)
  );

  always_comb begin
    w_state_next  = r_state;
    w_step_next   = r_step;
    w_retry_next  = r_retry;
    w_enter_step  = 1'b0;
    w_advance     = 1'b0;
    w_fail        = 1'b0;
    w_fail_target = 4'd0;

    // A timeout is tested first so it wins over a same-cycle tx_done/rx_valid.
    unique case (r_state)
      ST_STARTUP: begin
        if (w_startup_expired) begin
          w_state_next = ST_SEND;
          w_step_next  = 4'd0;
          w_enter_step = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_timeout_expired) begin
          w_fail = 1'b1;
        end else if (r_tx_valid && tx_ready) begin
          w_state_next = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (w_timeout_expired) begin
          w_fail = 1'b1;
        end else if (tx_done) begin
          w_advance = 1'b1;
        end
      end
      ST_WAIT_RX: begin
        if (w_timeout_expired) begin
          w_fail = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == step_code(r_step)) begin
            w_advance = 1'b1;
          end else begin
            w_fail = 1'b1;
            if (rx_data == PS2_RESEND) w_fail_target = prev_tx_step(r_step);
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (reinit) begin
          w_state_next = ST_SEND;
          w_step_next  = 4'd0;
          w_retry_next = 2'd0;
          w_enter_step = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_STARTUP;
      end
    endcase

    if (w_advance) begin
      if (r_step == LAST_STEP) begin
        w_state_next = ST_DONE;
      end else begin
        w_step_next  = r_step + 4'd1;
        w_state_next = step_is_tx(r_step + 4'd1) ? ST_SEND : ST_WAIT_RX;
        w_enter_step = 1'b1;
      end
    end

    if (w_fail) begin
      w_retry_next = r_retry + 2'd1;
      if (r_retry == RETRY_LAST) begin
        w_state_next = ST_ERROR;
      end else begin
        w_state_next = ST_SEND;
        w_step_next  = w_fail_target;
        w_enter_step = 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so tx_valid rises on SEND
  // entry and falls in the cycle after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_STARTUP;
      r_step       <= 4'd0;
      r_retry      <= 2'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_init_done  <= 1'b0;
      r_init_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_step       <= w_step_next;
      r_retry      <= w_retry_next;
      r_tx_valid   <= (w_state_next == ST_SEND);
      if (w_state_next == ST_SEND) r_tx_data <= step_code(w_step_next);
      r_init_done  <= (w_state_next == ST_DONE);
      r_init_error <= (w_state_next == ST_ERROR);
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign init_done  = r_init_done;
  assign init_error = r_init_error;
  assign step_idx   = r_step;
  assign retry_cnt  = r_retry;

endmodule
